// File: rtl/axi_lite_bram_ctrl_pkg.sv
// Shared types and constants for the AXI4-Lite to BRAM controller.
package bram_ctrl_pkg;

  localparam int STRB_WIDTH = 32 / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_RESP
  } state_t;

endpackage

// File: rtl/axi_lite_bram_ctrl_if.sv
// AXI4-Lite slave bus bundle (AW, W, B, AR, R channels).
interface axi_lite_bram_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic [2:0]              s_axi_awprot;
  logic                    s_axi_awvalid;
  logic                    s_axi_awready;
  logic [DATA_WIDTH-1:0]   s_axi_wdata;
  logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  logic [1:0]              s_axi_bresp;
  logic                    s_axi_bvalid;
  logic                    s_axi_bready;
  logic [ADDR_WIDTH-1:0]   s_axi_araddr;
  logic [2:0]              s_axi_arprot;
  logic                    s_axi_arvalid;
  logic                    s_axi_arready;
  logic [DATA_WIDTH-1:0]   s_axi_rdata;
  logic [1:0]              s_axi_rresp;
  logic                    s_axi_rvalid;
  logic                    s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_bready,
    input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    input  s_axi_rready,
    output s_axi_awready, s_axi_wready,
    output s_axi_bresp, s_axi_bvalid,
    output s_axi_arready,
    output s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport master (
    output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_bready,
    output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
    output s_axi_rready,
    input  s_axi_awready, s_axi_wready,
    input  s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready,
    input  s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/axi_lite_bram_ctrl.sv
// AXI4-Lite slave serialising single-beat reads/writes onto one BRAM port.
// Optional macro BRAM_CTRL_ADDR_CHECK_EN: accesses at byte address >= MEM_BYTES
// are handshaken normally but skip the BRAM and answer SLVERR (read data 0).
module axi_lite_bram_ctrl
  import bram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int BRAM_LATENCY = 1,
  parameter int MEM_BYTES    = 65536
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  axi_lite_bram_ctrl_if.slave     axi,
  output logic                    bram_rst_a,
  output logic                    bram_clk_a,
  output logic                    bram_en_a,
  output logic [DATA_WIDTH/8-1:0] bram_we_a,
  output logic [ADDR_WIDTH-1:0]   bram_addr_a,
  output logic [DATA_WIDTH-1:0]   bram_wrdata_a,
  input  logic [DATA_WIDTH-1:0]   bram_rddata_a
);

  localparam logic [1:0]          LAT_LAST  = 2'(BRAM_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_BYTES);

  state_t                state_q, state_d;
  logic                  last_wr_q, last_wr_d;   // last grant was a write
  logic [1:0]            cnt_q, cnt_d;           // RD_WAIT cycle counter
  logic                  rd_err_q, rd_err_d;     // in-flight read is out of range
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  resp_t                 rresp_q, rresp_d;
  resp_t                 bresp_q, bresp_d;

  logic aw_rdy, w_rdy, ar_rdy;
  logic wr_cand, rd_cand, aw_ok, ar_ok;

  assign bram_rst_a = ~s_axi_aresetn;
  assign bram_clk_a = s_axi_aclk;

  assign wr_cand = axi.s_axi_awvalid && axi.s_axi_wvalid;
  assign rd_cand = axi.s_axi_arvalid;

`ifdef BRAM_CTRL_ADDR_CHECK_EN
  assign aw_ok = ({1'b0, axi.s_axi_awaddr} < MEM_LIMIT);
  assign ar_ok = ({1'b0, axi.s_axi_araddr} < MEM_LIMIT);
`else
  assign aw_ok = 1'b1;
  assign ar_ok = 1'b1;
  logic unused_lim;
  assign unused_lim = ^MEM_LIMIT;
`endif

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_in;
  assign unused_in = ^{axi.s_axi_awprot, axi.s_axi_arprot,
                       axi.s_axi_awaddr[1:0], axi.s_axi_araddr[1:0]};

  assign axi.s_axi_awready = aw_rdy;
  assign axi.s_axi_wready  = w_rdy;
  assign axi.s_axi_arready = ar_rdy;
  assign axi.s_axi_bvalid  = (state_q == WR_RESP);
  assign axi.s_axi_bresp   = bresp_q;
  assign axi.s_axi_rvalid  = (state_q == RD_RESP);
  assign axi.s_axi_rresp   = rresp_q;
  assign axi.s_axi_rdata   = rdata_q;

  // State and response registers; reset abandons any transaction in flight.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b1;
      cnt_q     <= '0;
      rd_err_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      bresp_q   <= OKAY;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      cnt_q     <= cnt_d;
      rd_err_q  <= rd_err_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      bresp_q   <= bresp_d;
    end
  end

  // Arbitration, grant-cycle BRAM drive and next-state logic.
  always_comb begin
    state_d       = state_q;
    last_wr_d     = last_wr_q;
    cnt_d         = cnt_q;
    rd_err_d      = rd_err_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    bresp_d       = bresp_q;
    aw_rdy        = 1'b0;
    w_rdy         = 1'b0;
    ar_rdy        = 1'b0;
    bram_en_a     = 1'b0;
    bram_we_a     = '0;
    bram_addr_a   = '0;
    bram_wrdata_a = '0;
    case (state_q)
      IDLE: begin
        // Gating on reset keeps the combinational grant quiet while held in reset.
        if (s_axi_aresetn) begin
          if (rd_cand && (!wr_cand || last_wr_q)) begin
            ar_rdy    = 1'b1;
            last_wr_d = 1'b0;
            cnt_d     = '0;
            rd_err_d  = !ar_ok;
            state_d   = RD_WAIT;
            if (ar_ok) begin
              bram_en_a   = 1'b1;
              bram_addr_a = {axi.s_axi_araddr[ADDR_WIDTH-1:2], 2'b00};
            end
          end else if (wr_cand) begin
            aw_rdy    = 1'b1;
            w_rdy     = 1'b1;
            last_wr_d = 1'b1;
            bresp_d   = aw_ok ? OKAY : SLVERR;
            state_d   = WR_RESP;
            if (aw_ok) begin
              bram_en_a     = 1'b1;
              bram_we_a     = axi.s_axi_wstrb;
              bram_addr_a   = {axi.s_axi_awaddr[ADDR_WIDTH-1:2], 2'b00};
              bram_wrdata_a = axi.s_axi_wdata;
            end
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          rdata_d = rd_err_q ? '0 : bram_rddata_a;
          rresp_d = rd_err_q ? SLVERR : OKAY;
          state_d = RD_RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RD_RESP: if (axi.s_axi_rready) state_d = IDLE;
      WR_RESP: if (axi.s_axi_bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_bram_ctrl.sv
// Scoreboard bench for axi_lite_bram_ctrl with a behavioural 1-cycle BRAM.
module tb_axi_lite_bram_ctrl;
  import bram_ctrl_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
`ifdef BRAM_CTRL_ADDR_CHECK_EN
  localparam int MEMB = 4096;
`else
  localparam int MEMB = 65536;
`endif

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        bram_rst_a, bram_clk_a, bram_en_a;
  logic [3:0]  bram_we_a;
  logic [15:0] bram_addr_a;
  logic [31:0] bram_wrdata_a, bram_rddata_a;

  axi_lite_bram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi();

  axi_lite_bram_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BRAM_LATENCY(1), .MEM_BYTES(MEMB)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(aresetn),
    .axi          (axi),
    .bram_rst_a   (bram_rst_a),
    .bram_clk_a   (bram_clk_a),
    .bram_en_a    (bram_en_a),
    .bram_we_a    (bram_we_a),
    .bram_addr_a  (bram_addr_a),
    .bram_wrdata_a(bram_wrdata_a),
    .bram_rddata_a(bram_rddata_a)
  );

  always #5 clk = ~clk;

  // behavioural BRAM, read latency 1
  logic [31:0] mem [0:16383] = '{default: '0};
  logic [31:0] rd_q = '0;
  always @(posedge clk) begin
    if (bram_en_a) begin
      for (int b = 0; b < 4; b++)
        if (bram_we_a[b]) mem[bram_addr_a[15:2]][8*b +: 8] <= bram_wrdata_a[8*b +: 8];
      rd_q <= mem[bram_addr_a[15:2]];
    end
  end
  assign bram_rddata_a = rd_q;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;
  rexp_t      exp_r[$];
  logic [1:0] exp_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur as required at %0t", name, $time);
  endtask

  // monitor: pops expectations on each response handshake, checks hold behaviour
  logic        prev_rv = 0, prev_rr = 0, prev_bv = 0, prev_br = 0;
  logic [1:0]  prev_bs = '0;
  always @(negedge clk) begin : mon
    rexp_t e;
    logic [1:0] eb;
    if (prev_rv && !prev_rr) begin
      chk("r_hold_valid", 32'(axi.s_axi_rvalid), 32'd1);
      if (exp_r.size() > 0) chk("r_hold_data", axi.s_axi_rdata, exp_r[0].data);
    end
    if (prev_bv && !prev_br) begin
      chk("b_hold_valid", 32'(axi.s_axi_bvalid), 32'd1);
      chk("b_hold_resp", 32'(axi.s_axi_bresp), 32'(prev_bs));
    end
    if (axi.s_axi_rvalid || axi.s_axi_bvalid)
      chk("ready_while_resp",
          {29'd0, axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready}, 32'd0);
    if (axi.s_axi_rvalid && axi.s_axi_rready) begin
      if (exp_r.size() == 0) fail_now("r_unexpected");
      else begin
        e = exp_r.pop_front();
        chk("r_data", axi.s_axi_rdata, e.data);
        chk("r_resp", 32'(axi.s_axi_rresp), 32'(e.resp));
      end
    end
    if (axi.s_axi_bvalid && axi.s_axi_bready) begin
      if (exp_b.size() == 0) fail_now("b_unexpected");
      else begin
        eb = exp_b.pop_front();
        chk("b_resp", 32'(axi.s_axi_bresp), 32'(eb));
      end
    end
    prev_rv = axi.s_axi_rvalid;
    prev_rr = axi.s_axi_rready;
    prev_bv = axi.s_axi_bvalid;
    prev_br = axi.s_axi_bready;
    prev_bs = axi.s_axi_bresp;
  end

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] er, input logic een, input int hold);
    int n;
    exp_b.push_back(er);
    @(posedge clk); #1;
    axi.s_axi_awaddr  = a;
    axi.s_axi_wdata   = d;
    axi.s_axi_wstrb   = s;
    axi.s_axi_awvalid = 1'b1;
    axi.s_axi_wvalid  = 1'b1;
    axi.s_axi_bready  = (hold == 0);
    @(negedge clk);
    n = 0;
    while (!(axi.s_axi_awready && axi.s_axi_wready) && n < 20) begin
      @(negedge clk); n++;
    end
    if (!(axi.s_axi_awready && axi.s_axi_wready)) begin
      fail_now("wr_grant_timeout");
      @(posedge clk); #1;
      axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0; axi.s_axi_bready = 1'b1;
      return;
    end
    chk("wr_en", 32'(bram_en_a), 32'(een));
    chk("wr_we", 32'(bram_we_a), een ? 32'(s) : 32'd0);
    chk("wr_addr", 32'(bram_addr_a), een ? 32'({a[15:2], 2'b00}) : 32'd0);
    if (een) chk("wr_data", bram_wrdata_a, d);
    @(posedge clk); #1;
    axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wvalid  = 1'b0;
    @(negedge clk);
    chk("wr_bvalid_t1", 32'(axi.s_axi_bvalid), 32'd1);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 axi.s_axi_bready = 1'b1;
      @(negedge clk);
    end
    n = 0;
    while (!(axi.s_axi_bvalid && axi.s_axi_bready) && n < 20) begin
      @(negedge clk); n++;
    end
    if (!(axi.s_axi_bvalid && axi.s_axi_bready)) fail_now("wr_resp_timeout");
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [15:0] a, input logic [31:0] ed, input logic [1:0] er,
                          input logic een, input int hold);
    int n;
    rexp_t e;
    e.data = ed;
    e.resp = er;
    exp_r.push_back(e);
    @(posedge clk); #1;
    axi.s_axi_araddr  = a;
    axi.s_axi_arvalid = 1'b1;
    axi.s_axi_rready  = (hold == 0);
    @(negedge clk);
    n = 0;
    while (!axi.s_axi_arready && n < 20) begin
      @(negedge clk); n++;
    end
    if (!axi.s_axi_arready) begin
      fail_now("rd_grant_timeout");
      @(posedge clk); #1;
      axi.s_axi_arvalid = 1'b0; axi.s_axi_rready = 1'b1;
      return;
    end
    chk("rd_en", 32'(bram_en_a), 32'(een));
    chk("rd_we", 32'(bram_we_a), 32'd0);
    chk("rd_addr", 32'(bram_addr_a), een ? 32'({a[15:2], 2'b00}) : 32'd0);
    @(posedge clk); #1;
    axi.s_axi_arvalid = 1'b0;
    @(negedge clk);
    chk("rd_rvalid_t1", 32'(axi.s_axi_rvalid), 32'd0);
    @(negedge clk);
    chk("rd_rvalid_t2", 32'(axi.s_axi_rvalid), 32'd1);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 axi.s_axi_rready = 1'b1;
      @(negedge clk);
    end
    n = 0;
    while (!(axi.s_axi_rvalid && axi.s_axi_rready) && n < 20) begin
      @(negedge clk); n++;
    end
    if (!(axi.s_axi_rvalid && axi.s_axi_rready)) fail_now("rd_resp_timeout");
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    axi.s_axi_awprot = 3'd0;
    axi.s_axi_arprot = 3'd0;
    axi.s_axi_bready = 1'b1;
    axi.s_axi_rready = 1'b1;
    // requests pending during reset must not be granted
    axi.s_axi_awaddr  = 16'h0040;
    axi.s_axi_wdata   = 32'h5555_AAAA;
    axi.s_axi_wstrb   = 4'hF;
    axi.s_axi_araddr  = 16'h0040;
    axi.s_axi_awvalid = 1'b1;
    axi.s_axi_wvalid  = 1'b1;
    axi.s_axi_arvalid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(axi.s_axi_awready), 32'd0);
    chk("rst_wready", 32'(axi.s_axi_wready), 32'd0);
    chk("rst_arready", 32'(axi.s_axi_arready), 32'd0);
    chk("rst_bram_en", 32'(bram_en_a), 32'd0);
    chk("rst_bram_we", 32'(bram_we_a), 32'd0);
    chk("rst_bvalid", 32'(axi.s_axi_bvalid), 32'd0);
    chk("rst_rvalid", 32'(axi.s_axi_rvalid), 32'd0);
    chk("rst_rdata", axi.s_axi_rdata, 32'd0);
    chk("rst_bresp", 32'(axi.s_axi_bresp), 32'd0);
    chk("rst_rresp", 32'(axi.s_axi_rresp), 32'd0);
    chk("rst_bram_rst", 32'(bram_rst_a), 32'd1);
    axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wvalid  = 1'b0;
    axi.s_axi_arvalid = 1'b0;
    @(posedge clk); #1 aresetn = 1'b1;
    @(negedge clk);
    chk("bram_rst_released", 32'(bram_rst_a), 32'd0);

    // contested first grant: read wins, sees old data; write follows
    exp_r.push_back('{data: 32'h0, resp: OKAY});
    exp_b.push_back(OKAY);
    @(posedge clk); #1;
    axi.s_axi_awaddr  = 16'h0040;
    axi.s_axi_wdata   = 32'h1234_5678;
    axi.s_axi_wstrb   = 4'hF;
    axi.s_axi_araddr  = 16'h0040;
    axi.s_axi_awvalid = 1'b1;
    axi.s_axi_wvalid  = 1'b1;
    axi.s_axi_arvalid = 1'b1;
    @(negedge clk);
    chk("contest_arready", 32'(axi.s_axi_arready), 32'd1);
    chk("contest_awready", 32'(axi.s_axi_awready), 32'd0);
    @(posedge clk); #1 axi.s_axi_arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!axi.s_axi_awready && n < 20) begin @(negedge clk); n++; end
    chk("contest_wr_grant_cycle", 32'(n), 32'd2);
    @(posedge clk); #1;
    axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wvalid  = 1'b0;
    n = 0;
    while ((exp_r.size() != 0 || exp_b.size() != 0) && n < 30) begin @(negedge clk); n++; end
    if (exp_r.size() != 0 || exp_b.size() != 0) fail_now("contest_drain");
    axi_read(16'h0040, 32'h1234_5678, OKAY, 1'b1, 0);

    // basic write / read
    axi_write(16'h0010, 32'hDEAD_BEEF, 4'hF, OKAY, 1'b1, 0);
    axi_read (16'h0010, 32'hDEAD_BEEF, OKAY, 1'b1, 0);

    // partial strobes
    axi_write(16'h0020, 32'h1122_3344, 4'hF, OKAY, 1'b1, 0);
    axi_write(16'h0020, 32'hAABB_CCDD, 4'h5, OKAY, 1'b1, 0);
    axi_read (16'h0020, 32'h11BB_33DD, OKAY, 1'b1, 0);

    // zero strobe: enabled, no bytes written, OKAY
    axi_write(16'h0020, 32'hFFFF_FFFF, 4'h0, OKAY, 1'b1, 0);
    axi_read (16'h0020, 32'h11BB_33DD, OKAY, 1'b1, 0);

    // unaligned read address maps to its word
    axi_read (16'h0013, 32'hDEAD_BEEF, OKAY, 1'b1, 0);

    // backpressure on R with a write queued behind, then on B with a read queued
    fork
      axi_read(16'h0020, 32'h11BB_33DD, OKAY, 1'b1, 5);
      begin
        repeat (2) @(posedge clk);
        axi_write(16'h0030, 32'hCAFE_F00D, 4'hF, OKAY, 1'b1, 0);
      end
    join
    fork
      axi_write(16'h0034, 32'h0BAD_CAFE, 4'hF, OKAY, 1'b1, 5);
      begin
        repeat (2) @(posedge clk);
        axi_read(16'h0030, 32'hCAFE_F00D, OKAY, 1'b1, 0);
      end
    join
    axi_read(16'h0034, 32'h0BAD_CAFE, OKAY, 1'b1, 0);

    // reset during RD_WAIT: abandoned, no response
    @(posedge clk); #1;
    axi.s_axi_araddr  = 16'h0034;
    axi.s_axi_arvalid = 1'b1;
    axi.s_axi_rready  = 1'b1;
    @(negedge clk);
    chk("rstmid_grant", 32'(axi.s_axi_arready), 32'd1);
    @(posedge clk); #1;
    axi.s_axi_arvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("rstmid_rvalid", 32'(axi.s_axi_rvalid), 32'd0);
    chk("rstmid_rdata", axi.s_axi_rdata, 32'd0);
    chk("rstmid_bram_en", 32'(bram_en_a), 32'd0);
    chk("rstmid_bram_rst", 32'(bram_rst_a), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_rvalid_hold", 32'(axi.s_axi_rvalid), 32'd0);
    end
    @(posedge clk); #1 aresetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_no_resp", 32'(axi.s_axi_rvalid), 32'd0);
    end
    axi_read(16'h0010, 32'hDEAD_BEEF, OKAY, 1'b1, 0);

`ifdef BRAM_CTRL_ADDR_CHECK_EN
    // out-of-range accesses: handshaken, BRAM untouched, SLVERR
    axi_read (16'h1000, 32'h0, SLVERR, 1'b0, 0);
    axi_read (16'h0FFC, 32'h0, OKAY, 1'b1, 0);
    axi_write(16'h2000, 32'h7777_7777, 4'hF, SLVERR, 1'b0, 0);
    axi_read (16'h0010, 32'hDEAD_BEEF, OKAY, 1'b1, 0);
`endif

    repeat (3) @(negedge clk);
    chk("queues_drained", 32'(exp_r.size() + exp_b.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
